// File: rtl/uart_stream_tx.sv
// Byte-stream 8N1 UART transmitter with a small FIFO in front of the shift register.
// Bit period is 8 * prescale_i clocks, with a prescale of 0 treated as 1.
module uart_stream_tx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FBITS      = $clog2(FIFO_DEPTH)
) (
    input  logic             clock,
    input  logic             arst_n,
    input  logic [15:0]      prescale_i,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [7:0]       s_tdata,
    output logic             uart_tx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [FBITS:0]   level_o
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [FBITS:0] LevelFull = (FBITS+1)'(FIFO_DEPTH);

    state_e               state_q, state_d;
    logic [18:0]          timer_q, timer_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [15:0]          peff_q, peff_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic [FBITS-1:0]     wr_ptr_q, rd_ptr_q;
    logic [FBITS:0]       level_q;
    logic [7:0]           mem_q [FIFO_DEPTH];

    logic                 push, pop, fifo_empty, bit_end;
    logic [15:0]          peff_new;

    assign fifo_empty = (level_q == '0);
    assign s_tready   = (level_q != LevelFull);
    assign push       = s_tvalid && s_tready;
    assign bit_end    = (timer_q == '0);
    assign peff_new   = (prescale_i == 16'd0) ? 16'd1 : prescale_i;

    assign uart_tx_o  = tx_q;
    assign done_o     = done_q;
    assign level_o    = level_q;
    assign busy_o     = (state_q != StIdle) || !fifo_empty;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        peff_d  = peff_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    peff_d  = peff_new;
                    timer_d = {peff_new, 3'b000} - 19'd1;
                    idx_d   = 3'd0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (!bit_end) begin
                    timer_d = timer_q - 19'd1;
                end else begin
                    timer_d = {peff_q, 3'b000} - 19'd1;
                    state_d = StData;
                end
            end
            StData: begin
                if (!bit_end) begin
                    timer_d = timer_q - 19'd1;
                end else begin
                    timer_d = {peff_q, 3'b000} - 19'd1;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (!bit_end) begin
                    timer_d = timer_q - 19'd1;
                end else begin
                    done_d = 1'b1;
                    // Chain straight into the next start bit so queued frames have no gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        peff_d  = peff_new;
                        timer_d = {peff_new, 3'b000} - 19'd1;
                        idx_d   = 3'd0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line is driven from the registered state, so it trails the FSM by one clock.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            peff_q  <= 16'd1;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            peff_q  <= peff_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FBITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FBITS'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (FBITS+1)'(1);
                2'b01:   level_q <= level_q - (FBITS+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= s_tdata;
    end

endmodule
